fg_dac_write_if: RTL and testbench
==================================

Name: fg_dac_write_if

Overview:
- Sits directly downstream of the function-generator core.
- Consumes each generated sample and its one-cycle valid strobe, and drives the parallel DAC: data bus, active-low write strobe of programmable width, clear and power-down pins.
- Enforces data setup/hold around the write pulse and a DAC settling holdoff between writes.
- Buffers one sample that arrives during a transfer and flags overruns.

Parameters:
- BITWIDTH, 8, sample/DAC data width
- WR_PULSE_CYCLES, 2, cycles dac_wr_n_o held low (2 = 40 ns at 50 MHz, >20 ns spec)
- SETTLE_CYCLES, 500, holdoff cycles after write pulse (10 us at 50 MHz)
- CNT_WIDTH, 10, width of internal timing counter; must hold max(WR_PULSE_CYCLES, SETTLE_CYCLES)

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  asynchronous, active-high reset
- enable_i  in  1  output enable; low = ignore new samples, request DAC power-down
- data_i  in  BITWIDTH  sample from generator core
- valid_i  in  1  one-cycle strobe qualifying data_i
- clr_ovr_i  in  1  synchronous clear of overrun_o and drop_cnt_o
- dac_data_o  out  BITWIDTH  registered DAC data bus
- dac_wr_n_o  out  1  DAC write strobe, active low
- dac_clr_n_o  out  1  DAC clear, active low
- dac_pd_n_o  out  1  DAC power-down, active low
- busy_o  out  1  high in any state other than IDLE
- overrun_o  out  1  sticky: a buffered sample was overwritten
- drop_cnt_o  out  8  saturating count of overwritten samples

Behaviour:
- Interface: one clock (clk_i); reset is asynchronous and active-high (rst_i).
- Reset values:
  - dac_data_o = 0, dac_wr_n_o = 1, dac_clr_n_o = 0, dac_pd_n_o = 0, busy_o = 0, overrun_o = 0, drop_cnt_o = 0.
  - State = IDLE, pending buffer empty.
- After reset deasserts:
  - dac_clr_n_o goes to 1 on the first clock edge.
  - dac_pd_n_o is enable_i registered (one-cycle latency).
- All outputs are registered. No combinational path from inputs to outputs.
- FSM states: IDLE, SETUP, WR_LOW, HOLD, SETTLE.
  - IDLE: valid_i & enable_i at an edge -> dac_data_o <= data_i, go to SETUP.
  - SETUP: exactly 1 cycle. Data stable, dac_wr_n_o = 1. Then go to WR_LOW; dac_wr_n_o <= 0.
  - WR_LOW: dac_wr_n_o = 0 for exactly WR_PULSE_CYCLES cycles. Then go to HOLD; dac_wr_n_o <= 1.
  - HOLD: 1 cycle. Data unchanged, so the rising write edge has one cycle of hold. Then go to SETTLE.
  - SETTLE: SETTLE_CYCLES cycles. At exit:
    - pending full -> dac_data_o <= pending, pending cleared, go to SETUP.
    - otherwise -> go to IDLE.
- Load-to-load period = 2 + WR_PULSE_CYCLES + SETTLE_CYCLES cycles (504 with defaults).
- dac_data_o changes only on the load edge. It never changes while dac_wr_n_o = 0 or in HOLD.
- Pending buffer (depth 1), for valid_i & enable_i while not in IDLE:
  - Buffer empty -> store sample.
  - Buffer full and not consumed this edge -> overwrite with newest, overrun_o <= 1, drop_cnt_o += 1 (saturates at 255).
  - Same edge as SETTLE exit consumes pending -> old pending is loaded, new sample stored, no overrun.
- Enable:
  - enable_i low: valid_i ignored, pending cleared at next edge.
  - A transfer in progress always completes (wr pulse never truncated).
- clr_ovr_i takes priority over a simultaneous increment. Result: 0.
- Counter: a single down-counter loaded on each state entry (WR_PULSE_CYCLES-1, SETTLE_CYCLES-1); the state advances at 0.
- Reset mid-transfer: immediate return to reset values; dac_wr_n_o goes high asynchronously.

Decomposition:
- Shared include FG_dac_pkg.vh holds:
  - FSM state encodings (3-bit localparams).
  - Default timing constants: FG_WR_PULSE_CYCLES = 2, FG_SETTLE_CYCLES = 500, 50 MHz clock basis.
- One natural sub-module: fg_dac_timer (loadable CNT_WIDTH down-counter with load/value/zero flag).
- FSM, pending buffer and overrun logic stay in the parent.

Test Plan (bench overrides SETTLE_CYCLES = 8, WR_PULSE_CYCLES = 2 -> period 12):
- Reset -> all outputs at reset values. First edge after release -> dac_clr_n_o = 1; dac_pd_n_o follows enable_i = 1 one cycle later.
- Single valid_i with data 0xA5 at edge 0 -> dac_data_o = 0xA5 from edge 0; dac_wr_n_o low after edges 1..2 (two cycles), high after edge 3; busy_o falls after edge 12.
- Samples 0x11 at t=0, 0x22 at t=4 -> 0x22 loaded exactly 12 cycles after 0x11. Second write pulse identical. overrun_o = 0.
- Samples 0x11, 0x22, 0x33 within one period -> 0x33 written second, 0x22 never appears. overrun_o = 1, drop_cnt_o = 1. Pulse clr_ovr_i -> both 0.
- New valid_i on the exact SETTLE-exit edge with pending 0x22 -> 0x22 loaded, new 0x44 buffered and written next, no overrun. enable_i dropped mid-WR_LOW -> pulse completes at full width, pending cleared, later valid_i ignored.
- rst_i asserted during WR_LOW -> dac_wr_n_o = 1 and dac_data_o = 0 without waiting for a clock edge.

Source files
------------

// File: rtl/fg_dac_write_if_pkg.sv
// Shared constants for the function-generator DAC write path: FSM encodings,
// default timing (50 MHz clock basis) and a small saturating-count helper.
package fg_dac_write_if_pkg;

    localparam int FG_WR_PULSE_CYCLES = 2;
    localparam int FG_SETTLE_CYCLES   = 500;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_SETUP  = 3'd1;
    localparam logic [2:0] ST_WR_LOW = 3'd2;
    localparam logic [2:0] ST_HOLD   = 3'd3;
    localparam logic [2:0] ST_SETTLE = 3'd4;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/fg_dac_write_if_if.sv
// Sample hand-off from the generator core: data, one-cycle valid strobe and
// output enable. The core drives the master side, the DAC writer is the slave.
interface fg_dac_write_if_if #(
    parameter int BITWIDTH = 8
);
    logic                enable_i;
    logic [BITWIDTH-1:0] data_i;
    logic                valid_i;

    modport master (output enable_i, output data_i, output valid_i);
    modport slave  (input  enable_i, input  data_i, input  valid_i);
endinterface

// File: rtl/fg_dac_write_if_timer.sv
// Loadable down-counter used for the write-pulse and settling intervals;
// it parks at zero and flags it so the FSM can advance.
module fg_dac_write_if_timer #(
    parameter int CNT_WIDTH = 10
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 load_i,
    input  logic [CNT_WIDTH-1:0] value_i,
    output logic                 zero_o
);
    logic [CNT_WIDTH-1:0] cnt_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= value_i;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign zero_o = (cnt_q == '0);
endmodule

// File: rtl/fg_dac_write_if.sv
// Parallel DAC writer: paces generator samples through setup / write-low /
// hold / settle, buffering one sample that arrives mid-transfer.
module fg_dac_write_if
    import fg_dac_write_if_pkg::*;
#(
    parameter int BITWIDTH        = 8,
    parameter int WR_PULSE_CYCLES = FG_WR_PULSE_CYCLES,
    parameter int SETTLE_CYCLES   = FG_SETTLE_CYCLES,
    parameter int CNT_WIDTH       = 10
) (
    input  logic                clk_i,
    input  logic                rst_i,
    fg_dac_write_if_if.slave    gen_if,
    input  logic                clr_ovr_i,
    output logic [BITWIDTH-1:0] dac_data_o,
    output logic                dac_wr_n_o,
    output logic                dac_clr_n_o,
    output logic                dac_pd_n_o,
    output logic                busy_o,
    output logic                overrun_o,
    output logic [7:0]          drop_cnt_o
);
    localparam logic [CNT_WIDTH-1:0] WR_LOAD     = CNT_WIDTH'(WR_PULSE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] SETTLE_LOAD = CNT_WIDTH'(SETTLE_CYCLES - 1);

    logic [2:0]           state_q, state_d;
    logic [BITWIDTH-1:0]  data_q, data_d;
    logic [BITWIDTH-1:0]  pend_q, pend_d;
    logic                 pend_vld_q, pend_vld_d;
    logic                 ovr_q, ovr_d;
    logic [7:0]           drop_q, drop_d;
    logic                 wr_n_q, clr_n_q, pd_n_q, busy_q;

    logic                 accept;
    logic                 consume;
    logic                 direct;
    logic                 overwrite;
    logic                 tmr_load;
    logic [CNT_WIDTH-1:0] tmr_val;
    logic                 tmr_zero;

    assign accept = gen_if.valid_i & gen_if.enable_i;

    fg_dac_write_if_timer #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_timer (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .load_i  (tmr_load),
        .value_i (tmr_val),
        .zero_o  (tmr_zero)
    );

    // At settle exit the buffered sample wins; an empty buffer lets a sample
    // arriving on that same edge start the next transfer directly.
    always_comb begin
        state_d  = state_q;
        data_d   = data_q;
        tmr_load = 1'b0;
        tmr_val  = WR_LOAD;
        consume  = 1'b0;
        direct   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    data_d  = gen_if.data_i;
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                state_d  = ST_WR_LOW;
                tmr_load = 1'b1;
                tmr_val  = WR_LOAD;
            end
            ST_WR_LOW: begin
                if (tmr_zero) state_d = ST_HOLD;
            end
            ST_HOLD: begin
                state_d  = ST_SETTLE;
                tmr_load = 1'b1;
                tmr_val  = SETTLE_LOAD;
            end
            ST_SETTLE: begin
                if (tmr_zero) begin
                    if (pend_vld_q && gen_if.enable_i) begin
                        consume = 1'b1;
                        data_d  = pend_q;
                        state_d = ST_SETUP;
                    end else if (accept) begin
                        direct  = 1'b1;
                        data_d  = gen_if.data_i;
                        state_d = ST_SETUP;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        overwrite  = 1'b0;
        if (!gen_if.enable_i) begin
            pend_vld_d = 1'b0;
        end else if ((state_q != ST_IDLE) && accept && !direct) begin
            pend_d     = gen_if.data_i;
            pend_vld_d = 1'b1;
            overwrite  = pend_vld_q && !consume;
        end else if (consume) begin
            pend_vld_d = 1'b0;
        end
    end

    always_comb begin
        ovr_d  = ovr_q;
        drop_d = drop_q;
        if (clr_ovr_i) begin
            ovr_d  = 1'b0;
            drop_d = 8'd0;
        end else if (overwrite) begin
            ovr_d  = 1'b1;
            drop_d = sat_inc8(drop_q);
        end
    end

    // Strobe and busy are registered from the next state so they line up
    // with the state register rather than lagging it by a cycle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            data_q     <= '0;
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
            ovr_q      <= 1'b0;
            drop_q     <= 8'd0;
            wr_n_q     <= 1'b1;
            clr_n_q    <= 1'b0;
            pd_n_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            data_q     <= data_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            ovr_q      <= ovr_d;
            drop_q     <= drop_d;
            wr_n_q     <= (state_d != ST_WR_LOW);
            clr_n_q    <= 1'b1;
            pd_n_q     <= gen_if.enable_i;
            busy_q     <= (state_d != ST_IDLE);
        end
    end

    assign dac_data_o  = data_q;
    assign dac_wr_n_o  = wr_n_q;
    assign dac_clr_n_o = clr_n_q;
    assign dac_pd_n_o  = pd_n_q;
    assign busy_o      = busy_q;
    assign overrun_o   = ovr_q;
    assign drop_cnt_o  = drop_q;
endmodule

// File: tb/tb_fg_dac_write_if.sv
// Bench for fg_dac_write_if: directed scenarios plus random traffic, compared
// every cycle against a transfer-timeline model of the DAC writer.
module tb_fg_dac_write_if;
    localparam int BITWIDTH = 8;
    localparam int WR       = 2;
    localparam int SETTLE   = 8;
    localparam int PERIOD   = 2 + WR + SETTLE;

    logic                clk = 1'b0;
    logic                rst;
    logic                clrOvr;
    logic [BITWIDTH-1:0] dacData;
    logic                dacWrN, dacClrN, dacPdN, busy, overrun;
    logic [7:0]          dropCnt;

    fg_dac_write_if_if #(.BITWIDTH(BITWIDTH)) genIf ();

    fg_dac_write_if #(
        .BITWIDTH        (BITWIDTH),
        .WR_PULSE_CYCLES (WR),
        .SETTLE_CYCLES   (SETTLE),
        .CNT_WIDTH       (10)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .gen_if      (genIf),
        .clr_ovr_i   (clrOvr),
        .dac_data_o  (dacData),
        .dac_wr_n_o  (dacWrN),
        .dac_clr_n_o (dacClrN),
        .dac_pd_n_o  (dacPdN),
        .busy_o      (busy),
        .overrun_o   (overrun),
        .drop_cnt_o  (dropCnt)
    );

    always #5 clk = ~clk;

    int vectors    = 0;
    int miscompares = 0;

    // Model: a transfer is described only by the edge it was loaded on; all
    // pin timing is derived from the offset since that edge.
    int         cyc;
    bit         mActive;
    int         mLoad;
    logic [7:0] mData, mPend;
    bit         mPendFull, mOvr, mPdn, mClrn;
    int         mDrop;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic modelReset();
        cyc = 0; mActive = 0; mLoad = 0; mData = 8'h00; mPend = 8'h00;
        mPendFull = 0; mOvr = 0; mDrop = 0; mPdn = 0; mClrn = 0;
    endtask

    task automatic modelEdge(input bit en, input bit v, input logic [7:0] d, input bit clr);
        bit acc, was, consume, direct, over;
        acc = en && v; was = mActive; consume = 0; direct = 0; over = 0;
        if (!mActive) begin
            if (acc) begin mActive = 1; mLoad = cyc; mData = d; end
        end else if (cyc - mLoad == PERIOD) begin
            if (mPendFull && en) begin mLoad = cyc; mData = mPend; consume = 1; end
            else if (acc) begin mLoad = cyc; mData = d; direct = 1; end
            else mActive = 0;
        end
        if (!en) mPendFull = 0;
        else if (was && acc && !direct) begin
            over = mPendFull && !consume;
            mPend = d; mPendFull = 1;
        end else if (consume) mPendFull = 0;
        if (clr) begin mOvr = 0; mDrop = 0; end
        else if (over) begin mOvr = 1; if (mDrop < 255) mDrop++; end
        mPdn = en; mClrn = 1;
    endtask

    task automatic checkAll();
        int off;
        bit expWrN;
        off = cyc - mLoad;
        expWrN = !(mActive && off >= 1 && off <= WR);
        checkOutput("dac_data",  32'(dacData), 32'(mData));
        checkOutput("dac_wr_n",  32'(dacWrN),  32'(expWrN));
        checkOutput("busy",      32'(busy),    32'(mActive));
        checkOutput("dac_clr_n", 32'(dacClrN), 32'(mClrn));
        checkOutput("dac_pd_n",  32'(dacPdN),  32'(mPdn));
        checkOutput("overrun",   32'(overrun), 32'(mOvr));
        checkOutput("drop_cnt",  32'(dropCnt), 32'(mDrop));
    endtask

    task automatic applyStimulus(input bit en, input bit v, input logic [7:0] d, input bit clr);
        genIf.enable_i = en;
        genIf.valid_i  = v;
        genIf.data_i   = d;
        clrOvr         = clr;
        @(posedge clk);
        cyc++;
        modelEdge(en, v, d, clr);
        @(negedge clk);
        checkAll();
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b0, 8'($urandom), 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst = 1'b1; clrOvr = 1'b0;
        genIf.enable_i = 1'b1; genIf.valid_i = 1'b0; genIf.data_i = 8'h00;
        modelReset();
        repeat (3) @(negedge clk);
        checkAll();
        rst = 1'b0;

        // Power-down pin follows enable with one edge of latency.
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
        idleCycles(2);

        applyStimulus(1'b1, 1'b1, 8'hA5, 1'b0);
        idleCycles(PERIOD + 2);

        applyStimulus(1'b1, 1'b1, 8'h11, 1'b0);
        idleCycles(3);
        applyStimulus(1'b1, 1'b1, 8'h22, 1'b0);
        idleCycles(2 * PERIOD + 2);

        applyStimulus(1'b1, 1'b1, 8'h11, 1'b0);
        idleCycles(1);
        applyStimulus(1'b1, 1'b1, 8'h22, 1'b0);
        idleCycles(1);
        applyStimulus(1'b1, 1'b1, 8'h33, 1'b0);
        idleCycles(2 * PERIOD + 2);
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b1);
        idleCycles(1);

        // Sample arriving on the exact settle-exit edge while 0x22 is buffered.
        applyStimulus(1'b1, 1'b1, 8'h11, 1'b0);
        idleCycles(2);
        applyStimulus(1'b1, 1'b1, 8'h22, 1'b0);
        idleCycles(PERIOD - 4);
        applyStimulus(1'b1, 1'b1, 8'h44, 1'b0);
        idleCycles(2 * PERIOD + 2);

        applyStimulus(1'b1, 1'b1, 8'h55, 1'b0);
        applyStimulus(1'b1, 1'b1, 8'h66, 1'b0);
        for (int i = 0; i < PERIOD + 8; i++)
            applyStimulus(1'b0, 1'(i % 3 == 0), 8'($urandom), 1'b0);
        idleCycles(3);

        for (int i = 0; i < 600; i++)
            applyStimulus(1'($urandom_range(15) != 0), 1'($urandom_range(5) == 0),
                          8'($urandom), 1'($urandom_range(63) == 0));
        idleCycles(PERIOD + 2);

        // Continuous samples drive the drop counter into saturation.
        for (int i = 0; i < 330; i++) applyStimulus(1'b1, 1'b1, 8'($urandom), 1'b0);
        idleCycles(2 * PERIOD + 2);

        // Reset in the middle of the write pulse acts without a clock edge.
        applyStimulus(1'b1, 1'b1, 8'h77, 1'b0);
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("async_wr_n", 32'(dacWrN),  32'd1);
        checkOutput("async_data", 32'(dacData), 32'd0);
        checkOutput("async_busy", 32'(busy),    32'd0);
        modelReset();
        @(negedge clk);
        checkAll();
        rst = 1'b0;
        applyStimulus(1'b1, 1'b1, 8'h3C, 1'b0);
        idleCycles(PERIOD + 2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
